mem_access_unit: RTL and testbench

//  Load/store stage directly downstream of the ALU. Takes the ALU result as effective address,

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage after the ALU.
// It runs one data-bus transaction for each memory instruction and steers the byte lanes.
// It checks alignment, enforces a bus timeout and sign/zero-extends load results.
// busy stays high from the cycle after start until the done cycle, so the CPU stalls.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op_q, op_nxt;
    logic [1:0]       off_q, off_nxt;

    logic        busy_nxt, done_nxt, err_align_nxt, err_timeout_nxt;
    logic [31:0] rdata_nxt;
    logic        bus_req_nxt, bus_we_nxt;
    logic [31:0] bus_addr_nxt, bus_wdata_nxt;
    logic [3:0]  bus_be_nxt;

    logic        dec_legal, dec_misaligned;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [15:0] lane_h;
    logic [7:0]  lane_b;
    logic [31:0] load_val;

    // Decode the incoming instruction: legality, alignment, lane enables and store data
    always_comb begin
        dec_legal      = 1'b0;
        dec_misaligned = 1'b0;
        dec_be         = 4'b0000;
        dec_wdata      = 32'h0;
        case (mem_op[2:0])
            OP_B, OP_BU: begin
                dec_legal = (mem_op[2:0] == OP_B) || !mem_op[3];
                dec_be    = 4'b0001 << addr[1:0];
                dec_wdata = {4{wdata[7:0]}};
            end
            OP_H, OP_HU: begin
                dec_legal      = (mem_op[2:0] == OP_H) || !mem_op[3];
                dec_misaligned = addr[0];
                dec_be         = 4'b0011 << addr[1:0];
                dec_wdata      = {2{wdata[15:0]}};
            end
            OP_W: begin
                dec_legal      = 1'b1;
                dec_misaligned = (addr[1:0] != 2'b00);
                dec_be         = 4'b1111;
                dec_wdata      = wdata;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        if (!mem_op[3]) begin
            dec_wdata = 32'h0;
        end
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        lane_h   = 16'(bus_rdata >> {off_q, 3'b000});
        lane_b   = lane_h[7:0];
        load_val = bus_rdata;
        case (op_q)
            OP_B:    load_val = {{24{lane_b[7]}}, lane_b};
            OP_BU:   load_val = {24'h0, lane_b};
            OP_H:    load_val = {{16{lane_h[15]}}, lane_h};
            OP_HU:   load_val = {16'h0, lane_h};
            default: load_val = bus_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        op_nxt          = op_q;
        off_nxt         = off_q;
        rdata_nxt       = rdata;
        err_align_nxt   = 1'b0;
        err_timeout_nxt = 1'b0;
        bus_req_nxt     = bus_req;
        bus_we_nxt      = bus_we;
        bus_addr_nxt    = bus_addr;
        bus_be_nxt      = bus_be;
        bus_wdata_nxt   = bus_wdata;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!dec_legal) begin
                        rdata_nxt = 32'h0;
                        state_nxt = S_DONE;
                    end else if (dec_misaligned) begin
                        err_align_nxt = 1'b1;
                        state_nxt     = S_DONE;
                    end else begin
                        bus_req_nxt   = 1'b1;
                        bus_we_nxt    = mem_op[3];
                        bus_addr_nxt  = {addr[31:2], 2'b00};
                        bus_be_nxt    = dec_be;
                        bus_wdata_nxt = dec_wdata;
                        op_nxt        = mem_op[2:0];
                        off_nxt       = addr[1:0];
                        cnt_nxt       = '0;
                        state_nxt     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    bus_req_nxt = 1'b0;
                    if (!bus_we) begin
                        rdata_nxt = load_val;
                    end
                    state_nxt = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    bus_req_nxt     = 1'b0;
                    rdata_nxt       = 32'h0;
                    err_timeout_nxt = 1'b1;
                    state_nxt       = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                bus_req_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase

        done_nxt = (state_nxt == S_DONE);
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= 3'b000;
            off_q       <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= 32'h0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            op_q        <= op_nxt;
            off_q       <= off_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            rdata       <= rdata_nxt;
            err_align   <= err_align_nxt;
            err_timeout <= err_timeout_nxt;
            bus_req     <= bus_req_nxt;
            bus_we      <= bus_we_nxt;
            bus_addr    <= bus_addr_nxt;
            bus_be      <= bus_be_nxt;
            bus_wdata   <= bus_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed and randomized accesses against a reference model.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0011;
    localparam logic [3:0] LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SW  = 4'b1011;

    logic        clk, rst, start;
    logic [3:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        busy, done, err_align, err_timeout;
    logic [31:0] rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata = 32'h0;
    bit rdata_known = 1'b1;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .err_align(err_align), .err_timeout(err_timeout), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model helpers
    function automatic bit m_legal(input logic [3:0] op);
        case (op[2:0])
            3'b000, 3'b001, 3'b011: return 1'b1;
            3'b100, 3'b101:         return !op[3];
            default:                return 1'b0;
        endcase
    endfunction

    function automatic int m_size(input logic [3:0] op);
        case (op[2:0])
            3'b001, 3'b101: return 2;
            3'b011:         return 4;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] off,
                                           input int size, input bit sgn);
        logic [31:0] v;
        v = word >> (int'(off) * 8);
        if (size == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // One complete access; ack_at = REQ cycle (1-based) in which the bus acks, 0 = never
    task automatic run_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] word, input string name);
        bit legal, mis, do_bus, tmo;
        int size, reqs, done_cyc, exp_reqs, exp_done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld;
        legal  = m_legal(op);
        size   = m_size(op);
        mis    = legal && ((int'(a[1:0]) % size) != 0);
        do_bus = legal && !mis;
        tmo    = do_bus && (ack_at == 0 || ack_at > int'(TO));
        exp_be = 4'(((1 << size) - 1) << a[1:0]);
        exp_wd = (size == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                 (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
        exp_ld = m_load(word, a[1:0], size, !op[2]);
        exp_reqs = !do_bus ? 0 : (tmo ? int'(TO) : ack_at);
        exp_done = exp_reqs + 1;

        @(negedge clk);
        start = 1'b1; mem_op = op; addr = a; wdata = wd; bus_rdata = word;
        @(posedge clk); #1;
        reqs = 0; done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL %s busy cyc %0d: got %b want 1", name, c, busy);
            end
            if (bus_req === 1'b1) begin
                reqs++;
                checks++;
                if (bus_addr !== {a[31:2], 2'b00} || bus_be !== exp_be || bus_we !== op[3]) begin
                    errors++;
                    $display("FAIL %s bus fields: addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                             name, bus_addr, bus_be, bus_we, {a[31:2], 2'b00}, exp_be, op[3]);
                end
                if (op[3]) begin
                    checks++;
                    if (bus_wdata !== exp_wd) begin
                        errors++; $display("FAIL %s bus_wdata: got %h want %h", name, bus_wdata, exp_wd);
                    end
                end
            end
            if (done === 1'b1) done_cyc = c;
            @(negedge clk);
            start = 1'b0;
            bus_ack = (bus_req === 1'b1) && (reqs == ack_at);
            if (done_cyc == 0) begin
                @(posedge clk); #1;
            end
        end
        // Outputs are still those of the done cycle here (sampled before the negedge)
        checks++;
        if (done_cyc != exp_done) begin
            errors++; $display("FAIL %s done cycle: got %0d want %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (reqs != exp_reqs) begin
            errors++; $display("FAIL %s req cycles: got %0d want %0d", name, reqs, exp_reqs);
        end
        checks++;
        if (err_align !== mis || err_timeout !== tmo) begin
            errors++;
            $display("FAIL %s flags: align=%b timeout=%b want align=%b timeout=%b",
                     name, err_align, err_timeout, mis, tmo);
        end
        if (!legal || tmo) begin
            exp_rdata = 32'h0; rdata_known = 1'b1;
        end else if (mis) begin
            rdata_known = 1'b0;
        end else if (!op[3]) begin
            exp_rdata = exp_ld; rdata_known = 1'b1;
        end
        if (rdata_known) begin
            checks++;
            if (rdata !== exp_rdata) begin
                errors++; $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: busy=%b done=%b req=%b want 0 0 0", name, busy, done, bus_req);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err_align, err_timeout, bus_req, bus_we} !== 6'b0) begin
            errors++; $display("FAIL reset flags: got %b want 000000",
                               {busy, done, err_align, err_timeout, bus_req, bus_we});
        end
        checks++;
        if (rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'h0) begin
            errors++; $display("FAIL reset data: rdata=%h addr=%h wdata=%h be=%b want zeros",
                               rdata, bus_addr, bus_wdata, bus_be);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'h0; rdata_known = 1'b1;
    endtask

    task automatic test_directed();
        run_access(LW,  32'h100, 32'h0, 1, 32'hDEADBEEF, "lw_100");
        run_access(LB,  32'h103, 32'h0, 2, 32'h80112233, "lb_103");
        run_access(LBU, 32'h103, 32'h0, 1, 32'h80112233, "lbu_103");
        run_access(SH,  32'h202, 32'h0000ABCD, 1, 32'h0, "sh_202");
        run_access(LH,  32'h102, 32'h0, 3, 32'h9ABC5678, "lh_102");
        run_access(LHU, 32'h102, 32'h0, 1, 32'h9ABC5678, "lhu_102");
        run_access(SB,  32'h301, 32'h000000A5, 2, 32'h0, "sb_301");
        run_access(LW,  32'h101, 32'h0, 1, 32'h12345678, "lw_mis");
        run_access(LH,  32'h003, 32'h0, 1, 32'h12345678, "lh_mis");
        run_access(4'b0010, 32'h100, 32'h0, 1, 32'h12345678, "illegal");
    endtask

    task automatic test_timeout();
        run_access(LW, 32'h040, 32'h0, 0, 32'h55AA55AA, "lw_timeout");
        run_access(LW, 32'h044, 32'h0, 4, 32'h0F0F0F0F, "lw_ack_last");
        run_access(SW, 32'h048, 32'hCAFEF00D, 0, 32'h0, "sw_timeout");
    endtask

    task automatic test_random();
        logic [3:0] ops [14];
        logic [3:0] op;
        logic [31:0] a;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW,
                4'b0010, 4'b0110, 4'b0111, 4'b1010, 4'b1110, 4'b1111};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(13, 0)];
            a  = $urandom();
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            run_access(op, a, $urandom(), int'($urandom_range(5, 0)), $urandom(), "random");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; mem_op = LW; addr = 32'h300; bus_rdata = 32'h11111111;
        @(posedge clk); #1;
        @(negedge clk); bus_ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || rdata !== 32'h11111111) begin
            errors++; $display("FAIL b2b first: done=%b rdata=%h want 1 11111111", done, rdata);
        end
        @(negedge clk); bus_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b idle gap: busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk); mem_op = LHU; addr = 32'h306; bus_rdata = 32'hBEEF1234;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h304 || bus_be !== 4'b1100) begin
            errors++; $display("FAIL b2b second req: req=%b addr=%h be=%b want 1 00000304 1100",
                               bus_req, bus_addr, bus_be);
        end
        @(negedge clk); start = 1'b0; bus_ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || rdata !== 32'h0000BEEF) begin
            errors++; $display("FAIL b2b second done: done=%b rdata=%h want 1 0000beef", done, rdata);
        end
        exp_rdata = 32'h0000BEEF; rdata_known = 1'b1;
        @(negedge clk); bus_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_during_req();
        @(negedge clk);
        start = 1'b1; mem_op = LW; addr = 32'h500; bus_rdata = 32'h77777777;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL rst_req pre: bus_req=%b want 1", bus_req);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_req edge: req=%b busy=%b done=%b want 0 0 0", bus_req, busy, done);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); bus_ack = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
                errors++; $display("FAIL rst_req late ack: req=%b busy=%b done=%b rdata=%h want 0 0 0 0",
                                   bus_req, busy, done, rdata);
            end
        end
        exp_rdata = 32'h0; rdata_known = 1'b1;
    endtask

    task automatic test_ack_outside_req();
        @(negedge clk); bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || rdata !== exp_rdata) begin
                errors++; $display("FAIL stray ack: busy=%b done=%b rdata=%h want 0 0 %h",
                                   busy, done, rdata, exp_rdata);
            end
        end
        @(negedge clk); bus_ack = 1'b0;
        run_access(LB, 32'h600, 32'h0, 2, 32'h0000007F, "after_stray");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_op = 4'h0; addr = 32'h0; wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_rst_during_req();
        test_ack_outside_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
